// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT widths, complex types and twiddle constants
package fft_pkg;
    localparam int FFT_DATA_W = 16;
    localparam int FFT_TW_W   = 16;

    typedef struct packed {
        logic signed [FFT_DATA_W-1:0] re;
        logic signed [FFT_DATA_W-1:0] im;
    } cplx_data_t;

    typedef struct packed {
        logic signed [FFT_TW_W-1:0] re;
        logic signed [FFT_TW_W-1:0] im;
    } cplx_tw_t;

    localparam cplx_tw_t TW_0    = 32'h7fff_0000;
    localparam cplx_tw_t TW_N45  = 32'h5a82_a57e;
    localparam cplx_tw_t TW_N90  = 32'h0000_8000;
    localparam cplx_tw_t TW_N135 = 32'ha57e_a57e;
endpackage

// File: rtl/cplx_mult_round.sv
// cplx_mult_round: registered B*W complex multiply with round-half-up to DATA_W+1 bits
module cplx_mult_round
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int TW_W   = FFT_TW_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [2*DATA_W-1:0]      b,
    input  logic [2*TW_W-1:0]        w,
    output logic signed [DATA_W:0]   p_re,
    output logic signed [DATA_W:0]   p_im
);
    localparam int FW = DATA_W + TW_W + 1;
    localparam logic signed [FW-1:0] RND = FW'(1 << (TW_W - 2));

    logic signed [FW-1:0] br, bi, wr, wi, full_re, full_im;
    logic signed [DATA_W:0] p_re_d, p_re_q, p_im_d, p_im_q;

    always_comb begin
        br      = FW'(signed'(b[2*DATA_W-1:DATA_W]));
        bi      = FW'(signed'(b[DATA_W-1:0]));
        wr      = FW'(signed'(w[2*TW_W-1:TW_W]));
        wi      = FW'(signed'(w[TW_W-1:0]));
        full_re = br * wr - bi * wi;
        full_im = br * wi + bi * wr;
        p_re_d  = en ? (DATA_W+1)'((full_re + RND) >>> (TW_W - 1)) : p_re_q;
        p_im_d  = en ? (DATA_W+1)'((full_im + RND) >>> (TW_W - 1)) : p_im_q;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            p_re_q <= '0;
            p_im_q <= '0;
        end else begin
            p_re_q <= p_re_d;
            p_im_q <= p_im_d;
        end

    assign p_re = p_re_q;
    assign p_im = p_im_q;
endmodule

// File: rtl/butterfly_pipe.sv
// butterfly_pipe: 3-stage radix-2 DIT butterfly with valid/ready, scaling and saturation
module butterfly_pipe
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int TW_W   = FFT_TW_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*DATA_W-1:0]   in_a,
    input  logic [2*DATA_W-1:0]   in_b,
    input  logic [2*TW_W-1:0]     in_w,
    input  logic                  in_scale,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DATA_W-1:0]   out_a,
    output logic [2*DATA_W-1:0]   out_b,
    output logic                  out_sat,
    output logic                  ovf_sticky,
    input  logic                  ovf_clr
);
    localparam int DW2 = DATA_W + 2;
    localparam logic [DATA_W-1:0] OMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] OMIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DW2-1:0] SMAX = DW2'(signed'(OMAX));
    localparam logic signed [DW2-1:0] SMIN = DW2'(signed'(OMIN));

    logic adv;
    logic v1_d, v1_q, v2_d, v2_q, s1_d, s1_q, s2_d, s2_q;
    logic out_valid_d, out_valid_q, out_sat_d, out_sat_q, ovf_d, ovf_q;
    logic [2*DATA_W-1:0] a1_d, a1_q, b1_d, b1_q, a2_d, a2_q;
    logic [2*DATA_W-1:0] out_a_d, out_a_q, out_b_d, out_b_q;
    logic [2*TW_W-1:0] w1_d, w1_q;
    logic signed [DATA_W:0] p_re, p_im;
    logic signed [DW2-1:0] sum [4];
    logic signed [DW2-1:0] scl [4];
    logic [DATA_W-1:0] res [4];
    logic [3:0] sat;

    cplx_mult_round #(.DATA_W(DATA_W), .TW_W(TW_W)) u_mult (
        .clk  (clk),
        .rst  (rst),
        .en   (adv),
        .b    (b1_q),
        .w    (w1_q),
        .p_re (p_re),
        .p_im (p_im)
    );

    always_comb begin
        adv    = !out_valid_q || out_ready;
        v1_d   = adv ? in_valid : v1_q;
        a1_d   = adv ? in_a : a1_q;
        b1_d   = adv ? in_b : b1_q;
        w1_d   = adv ? in_w : w1_q;
        s1_d   = adv ? in_scale : s1_q;
        v2_d   = adv ? v1_q : v2_q;
        a2_d   = adv ? a1_q : a2_q;
        s2_d   = adv ? s1_q : s2_q;
        sum[0] = DW2'(signed'(a2_q[2*DATA_W-1:DATA_W])) + DW2'(p_re);
        sum[1] = DW2'(signed'(a2_q[DATA_W-1:0])) + DW2'(p_im);
        sum[2] = DW2'(signed'(a2_q[2*DATA_W-1:DATA_W])) - DW2'(p_re);
        sum[3] = DW2'(signed'(a2_q[DATA_W-1:0])) - DW2'(p_im);
        sat    = '0;
        for (int k = 0; k < 4; k++) begin
            scl[k] = s2_q ? (sum[k] + DW2'(1)) >>> 1 : sum[k];
            sat[k] = (scl[k] > SMAX) || (scl[k] < SMIN);
            res[k] = (scl[k] > SMAX) ? OMAX : (scl[k] < SMIN) ? OMIN : scl[k][DATA_W-1:0];
        end
        out_valid_d = adv ? v2_q : out_valid_q;
        out_a_d     = adv ? {res[0], res[1]} : out_a_q;
        out_b_d     = adv ? {res[2], res[3]} : out_b_q;
        out_sat_d   = adv ? (v2_q && |sat) : out_sat_q;
        // a saturating load into S3 beats a simultaneous clear
        ovf_d       = (adv && v2_q && |sat) || (ovf_q && !ovf_clr);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            a1_q        <= '0;
            b1_q        <= '0;
            w1_q        <= '0;
            a2_q        <= '0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_sat_q   <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            a1_q        <= a1_d;
            b1_q        <= b1_d;
            w1_q        <= w1_d;
            a2_q        <= a2_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_sat_q   <= out_sat_d;
            ovf_q       <= ovf_d;
        end

    assign in_ready   = adv;
    assign out_valid  = out_valid_q;
    assign out_a      = out_a_q;
    assign out_b      = out_b_q;
    assign out_sat    = out_sat_q;
    assign ovf_sticky = ovf_q;
endmodule

// File: tb/tb_butterfly_pipe.sv
// tb_butterfly_pipe: directed vectors, corner sequences and random scoreboard for butterfly_pipe
module tb_butterfly_pipe;
    import fft_pkg::*;

    typedef struct {
        logic [31:0] a, b, w;
        logic        sc;
        logic [31:0] ea, eb;
        logic        es;
    } vec_t;

    typedef struct packed {
        logic [31:0] a, b;
        logic        s;
    } exp_t;

    logic clk, rst, in_valid, in_ready, in_scale, out_valid, out_ready, out_sat, ovf_sticky, ovf_clr;
    logic [31:0] in_a, in_b, in_w, out_a, out_b;

    int checks = 0, errors = 0, n_in = 0, n_out = 0;
    exp_t exp_q[$];
    logic last_ov, last_ir, last_sat, hold_pend = 1'b0;
    logic [31:0] last_a, last_b, held_a, held_b;
    vec_t vecs[6];
    logic [31:0] tw_pool[4];

    butterfly_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_w(in_w), .in_scale(in_scale),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .out_sat(out_sat), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic longint wrap17(input longint x);
        longint y;
        y = x & 64'h1ffff;
        return (y >= 65536) ? y - 131072 : y;
    endfunction

    // Reference: A +/- round(B*W), optional halving, clamp to 16-bit signed
    function automatic void model(input logic [31:0] a, b, w, input logic sc,
                                  output logic [31:0] ea, eb, output logic es);
        longint ar, ai, br, bi, wr, wi, pr, pi;
        longint s[4];
        logic [15:0] r[4];
        ar = $signed(a[31:16]); ai = $signed(a[15:0]);
        br = $signed(b[31:16]); bi = $signed(b[15:0]);
        wr = $signed(w[31:16]); wi = $signed(w[15:0]);
        pr = wrap17((br * wr - bi * wi + 16384) >>> 15);
        pi = wrap17((br * wi + bi * wr + 16384) >>> 15);
        s[0] = ar + pr; s[1] = ai + pi; s[2] = ar - pr; s[3] = ai - pi;
        es = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (sc) s[k] = (s[k] + 1) >>> 1;
            if (s[k] > 32767) begin s[k] = 32767; es = 1'b1; end
            else if (s[k] < -32768) begin s[k] = -32768; es = 1'b1; end
            r[k] = s[k][15:0];
        end
        ea = {r[0], r[1]};
        eb = {r[2], r[3]};
    endfunction

    task automatic step();
        exp_t e;
        logic [31:0] ma, mb;
        logic ms;
        @(negedge clk);
        last_ov = out_valid; last_ir = in_ready; last_a = out_a; last_b = out_b; last_sat = out_sat;
        if (hold_pend) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_a", out_a, held_a);
            chk("hold_b", out_b, held_b);
        end
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out: got out_a %0h required no output", out_a);
            end else begin
                e = exp_q.pop_front();
                chk("sb_a", out_a, e.a);
                chk("sb_b", out_b, e.b);
                chk("sb_sat", out_sat, e.s);
            end
        end
        if (in_valid && in_ready) begin
            model(in_a, in_b, in_w, in_scale, ma, mb, ms);
            exp_q.push_back('{a: ma, b: mb, s: ms});
            n_in++;
        end
        hold_pend = out_valid && !out_ready;
        held_a = out_a; held_b = out_b;
        @(posedge clk); #1;
    endtask

    task automatic send_one(input vec_t v);
        int lat;
        in_a = v.a; in_b = v.b; in_w = v.w; in_scale = v.sc; in_valid = 1'b1; out_ready = 1'b1;
        step();
        chk("accept_ready", last_ir, 1);
        in_valid = 1'b0;
        lat = 0;
        do begin step(); lat++; end while (!last_ov && lat < 10);
        chk("latency", lat, 3);
        chk("vec_a", last_a, v.ea);
        chk("vec_b", last_b, v.eb);
        chk("vec_sat", last_sat, v.es);
    endtask

    initial begin
        int c, guard, n0, o0, stale;
        logic saw_ir_low;
        vecs[0] = '{32'h3fff_3fff, 32'h3fff_3fff, TW_0, 1'b0, 32'h7ffe_7ffe, 32'h0000_0000, 1'b0};
        vecs[1] = '{32'h3fff_3fff, 32'h3fff_3fff, TW_0, 1'b1, 32'h3fff_3fff, 32'h0000_0000, 1'b0};
        vecs[2] = '{32'h3fff_3fff, 32'hc000_c000, TW_N90, 1'b0, 32'hffff_7fff, 32'h7fff_ffff, 1'b0};
        vecs[3] = '{32'h0000_0000, 32'h4000_0000, TW_N45, 1'b0, 32'h2d41_d2bf, 32'hd2bf_2d41, 1'b0};
        vecs[4] = '{32'h7fff_0000, 32'h7fff_0000, TW_0, 1'b0, 32'h7fff_0000, 32'h0001_0000, 1'b1};
        vecs[5] = '{32'h7fff_0000, 32'h7fff_0000, TW_0, 1'b1, 32'h7fff_0000, 32'h0001_0000, 1'b0};
        tw_pool = '{TW_0, TW_N45, TW_N90, TW_N135};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
        in_a = '0; in_b = '0; in_w = '0; in_scale = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_a", out_a, 0);
        chk("rst_out_b", out_b, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_ovf", ovf_sticky, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        chk("ovf_before_sat", ovf_sticky, 0);
        for (int i = 0; i < 6; i++) send_one(vecs[i]);
        chk("ovf_held", ovf_sticky, 1);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        chk("ovf_cleared", ovf_sticky, 0);

        // backpressure: 6 back-to-back, sink stalled in cycles 4-8
        n0 = n_in; o0 = n_out; saw_ir_low = 1'b0;
        for (c = 0; c < 20; c++) begin
            in_valid = (n_in - n0) < 6;
            in_a = $urandom; in_b = $urandom; in_w = tw_pool[c % 4]; in_scale = c[0];
            out_ready = !(c >= 4 && c <= 8);
            step();
            if (in_valid && !last_ir) saw_ir_low = 1'b1;
        end
        in_valid = 1'b0;
        chk("bp_ready_drop", saw_ir_low, 1);
        chk("bp_count_in", n_in - n0, 6);
        chk("bp_count_out", n_out - o0, 6);
        chk("bp_queue_empty", exp_q.size(), 0);

        // reset with three in flight and ovf set
        out_ready = 1'b0; in_valid = 1'b1;
        in_a = vecs[4].a; in_b = vecs[4].b; in_w = vecs[4].w; in_scale = 1'b0;
        repeat (3) step();
        in_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_ovf", ovf_sticky, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_ovf", ovf_sticky, 0);
        chk("async_out_a", out_a, 0);
        chk("async_out_sat", out_sat, 0);
        exp_q.delete(); hold_pend = 1'b0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1; stale = 0;
        repeat (5) begin step(); if (last_ov) stale++; end
        chk("no_stale", stale, 0);
        send_one(vecs[0]);

        // clear races with a saturating load into S3
        chk("race_pre_ovf", ovf_sticky, 0);
        in_a = vecs[4].a; in_b = vecs[4].b; in_w = vecs[4].w; in_scale = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("race_set_wins", ovf_sticky, 1);
        repeat (3) step();

        // random traffic against the reference model
        n0 = n_in; guard = 0;
        while ((n_in - n0) < 1000 && guard < 20000) begin
            in_valid = ($urandom_range(3) != 0) && ((n_in - n0) < 1000);
            in_a = $urandom; in_b = $urandom;
            in_w = $urandom_range(1) ? tw_pool[$urandom_range(3)] : $urandom;
            in_scale = $urandom_range(1);
            out_ready = $urandom_range(9) < 7;
            step();
            guard++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("rand_accepted", n_in - n0, 1000);
        guard = 0;
        while (exp_q.size() > 0 && guard < 100) begin step(); guard++; end
        chk("rand_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/butterfly_pipe.md
Name: butterfly_pipe

Overview:
Parametrised, pipelined radix-2 DIT butterfly for the FFT datapath. It is the successor to the combinational butterfly and adds configurable data and twiddle widths, a fixed 3-stage pipeline, and a valid/ready handshake with backpressure. It also adds per-transaction optional divide-by-2 scaling, convergent-free round-half-up, output saturation, and a sticky overflow flag. It sits between the FFT sample RAM read port and the write-back path, with the twiddle supplied from the twiddle ROM.

Parameters:
DATA_W, 16, signed two's-complement width of each real/imag component of A, B and the outputs
TW_W, 16, signed Q1.(TW_W-1) twiddle component width; 0x7FFF ≈ +1, 0x8000 = -1

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input transaction valid
in_ready  out  1  block accepts input this cycle
in_a  in  2*DATA_W  {A_real, A_imag}
in_b  in  2*DATA_W  {B_real, B_imag}
in_w  in  2*TW_W  {W_real, W_imag}
in_scale  in  1  1 = divide both outputs by 2 (with rounding) for this transaction
out_valid  out  1  output transaction valid
out_ready  in  1  downstream accepts output
out_a  out  2*DATA_W  {A'_real, A'_imag} = A + B*W
out_b  out  2*DATA_W  {B'_real, B'_imag} = A - B*W
out_sat  out  1  this output transaction saturated at least one component
ovf_sticky  out  1  set when any transaction saturates; held until ovf_clr or rst
ovf_clr  in  1  synchronous clear of ovf_sticky

Behaviour:
- Reset (async, immediate): all stage valid bits = 0, out_valid = 0, out_a = out_b = 0, out_sat = 0, ovf_sticky = 0. Any in-flight data is discarded. in_ready = 1 after reset.
- Pipeline: S1 registers the inputs. S2 computes the complex product. S3 computes add/sub, scale and saturate, and drives the outputs. Latency is 3 cycles from the accept edge to out_valid with no stall.
- Handshake: advance = !out_valid || out_ready. in_ready = advance. The entire pipeline holds when advance = 0. Input is accepted on in_valid && in_ready. Output is consumed on out_valid && out_ready. Outputs are stable while out_valid && !out_ready. Throughput is 1 per cycle. Bubbles propagate as valid = 0.
- S2 product: Pr = Br*Wr - Bi*Wi and Pi = Br*Wi + Bi*Wr.
  - Full precision is DATA_W+TW_W+1 bits.
  - Round half up: add 2^(TW_W-2), then arithmetic shift right by TW_W-1.
  - The result is kept at DATA_W+1 bits, which covers the -1*-1 case.
- S3 add/sub: the sums are computed at DATA_W+2 bits.
  - If scale = 1: add 1, then arithmetic shift right by 1.
  - Saturate each of the 4 components to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - out_sat = OR of the 4 component saturations.
- ovf_sticky: set when a transaction with out_sat = 1 is loaded into S3 (loaded, not consumed). ovf_clr clears it. If set and clear occur in the same cycle, set wins.
- in_scale travels with its sample through the pipeline. Mixed-scale streams are legal.

Decomposition:
- Package fft_pkg holds:
  - the DATA_W/TW_W defaults;
  - a typedef for complex {re, im} of DATA_W and of TW_W;
  - twiddle constants TW_0 = 32'h7fff_0000, TW_N45 = 32'h5a82_a57e, TW_N90 = 32'h0000_8000, TW_N135 = 32'ha57e_a57e.
- One sub-module, cplx_mult_round: the S2 complex multiply with rounding, registered output, and an enable input driven by advance.

Test Plan:
- Unity twiddle, no scale: A = B = (16383, 16383), W = (32767, 0) -> out_a = (32766, 32766), out_b = (0, 0), out_sat = 0, 3 cycles after accept. With scale = 1 -> out_a = (16383, 16383), out_b = (0, 0).
- -90° twiddle: A = (16383, 16383), B = (-16384, -16384), W = (0, -32768) -> Bw = (-16384, 16384), out_a = (-1, 32767), out_b = (32767, -1), out_sat = 0.
- Saturation: A = (32767, 0), B = (32767, 0), W = (32767, 0), scale = 0 -> out_a = (32767, 0), out_b = (1, 0), out_sat = 1, ovf_sticky = 1 until ovf_clr. Same input with scale = 1 -> out_a = (32767, 0), out_b = (1, 0), out_sat = 0.
- Backpressure: stream 6 transactions with in_valid = 1, out_ready = 0 for cycles 4-8.
  - in_ready drops once S3 is full.
  - out_a is held stable during the stall.
  - All 6 outputs emerge in order, with no loss or duplication.
  - Random out_ready for 1000 transactions matches the bit-exact golden model.
- Reset mid-operation: assert rst while 3 transactions are in flight and ovf_sticky = 1.
  - out_valid = 0 and ovf_sticky = 0 immediately, without waiting for a clock edge.
  - After release, no stale outputs appear and the first new transaction has latency 3.
- Sticky clear race: ovf_clr = 1 in the same cycle a saturating transaction enters S3 -> ovf_sticky = 1.
